// File: rtl/rr_stream_arbiter_pkg.sv
// Shared types and index helpers for the round-robin stream arbiter.
package rr_stream_arbiter_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Wrap-around increment of a requester index in the range [0, n).
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  // Width of an index into n items; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_stream_arbiter_pick.sv
// Rotating priority encoder: first set request at or after ptr, modulo N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any_req
);

  // Scan from the farthest offset back to ptr so the nearest request wins.
  always_comb begin
    gnt_idx = '0;
    any_req = |req;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (req[(32'(ptr) + 32'(k)) % N_REQ]) begin
        gnt_idx = PTR_W'((32'(ptr) + 32'(k)) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin merge of N_REQ valid/ready streams with bounded bursts and a registered output.
// RR_STREAM_ARBITER_SRC_ID_EN adds down_src, the index of the requester that produced each beat.
module rr_stream_arbiter
  import rr_stream_arbiter_pkg::*;
#(
  parameter int unsigned D_WIDTH   = 6,
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ*D_WIDTH-1:0]   up_data,
  input  logic [N_REQ-1:0]           up_valid,
  output logic [N_REQ-1:0]           up_ready,
  output logic [D_WIDTH-1:0]         down_data,
  output logic                       down_valid,
  input  logic                       down_ready
`ifdef RR_STREAM_ARBITER_SRC_ID_EN
  ,
  output logic [$clog2(N_REQ)-1:0]   down_src
`endif
);

  localparam int unsigned PTR_W = idx_width(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t         state, state_n;
  logic [PTR_W-1:0]   ptr, ptr_n, owner, owner_n, start, gnt;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               ld, any_req, hold_rel, xfer, dv_n;
  logic [D_WIDTH-1:0] dd_n;
`ifdef RR_STREAM_ARBITER_SRC_ID_EN
  logic [PTR_W-1:0]   src_n;
`endif

  // A holder that drops valid releases at once; search resumes just past it.
  always_comb begin
    ld       = !down_valid || down_ready;
    hold_rel = (state == HOLD) && !up_valid[owner];
    if (state == ARB)  start = ptr;
    else if (hold_rel) start = PTR_W'(next_idx(32'(owner), N_REQ));
    else               start = owner;
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (up_valid),
    .ptr     (start),
    .gnt_idx (gnt),
    .any_req (any_req)
  );

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    owner_n  = owner;
    cnt_n    = cnt;
    dv_n     = down_valid;
    dd_n     = down_data;
    xfer     = 1'b0;
    up_ready = '0;
`ifdef RR_STREAM_ARBITER_SRC_ID_EN
    src_n    = down_src;
`endif
    if (ld) begin
      dv_n = 1'b0;
      xfer = any_req;
      if (hold_rel) begin
        state_n = ARB;
        ptr_n   = PTR_W'(next_idx(32'(owner), N_REQ));
        cnt_n   = '0;
      end
      if (xfer) begin
        up_ready[gnt] = 1'b1;
        dv_n          = 1'b1;
        dd_n          = up_data[32'(gnt)*D_WIDTH +: D_WIDTH];
`ifdef RR_STREAM_ARBITER_SRC_ID_EN
        src_n         = gnt;
`endif
        if (state == ARB || hold_rel) begin
          if (MAX_BURST == 1) begin
            state_n = ARB;
            ptr_n   = PTR_W'(next_idx(32'(gnt), N_REQ));
          end else begin
            state_n = HOLD;
            owner_n = gnt;
            cnt_n   = CNT_W'(1);
          end
        end else if (cnt + CNT_W'(1) == CNT_W'(MAX_BURST)) begin
          state_n = ARB;
          ptr_n   = PTR_W'(next_idx(32'(owner), N_REQ));
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB;
      ptr        <= '0;
      owner      <= '0;
      cnt        <= '0;
      down_valid <= 1'b0;
      down_data  <= '0;
`ifdef RR_STREAM_ARBITER_SRC_ID_EN
      down_src   <= '0;
`endif
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      owner      <= owner_n;
      cnt        <= cnt_n;
      down_valid <= dv_n;
      down_data  <= dd_n;
`ifdef RR_STREAM_ARBITER_SRC_ID_EN
      down_src   <= src_n;
`endif
    end
  end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench: one arbiter with MAX_BURST=1 and one with MAX_BURST=4 run side by side.
module tb_rr_stream_arbiter;

  logic        clk, rst;
  logic [3:0]  v1, v4, ur1, ur4;
  logic        dr1, dr4, dv1, dv4;
  logic [5:0]  dd1, dd4;
  logic [23:0] ud1, ud4;
  logic [3:0]  seq1 [4];
  logic [3:0]  seq4 [4];
  int          tests = 0;
  int          fails = 0;
`ifdef RR_STREAM_ARBITER_SRC_ID_EN
  logic [1:0]  ds1, ds4;
`endif

  rr_stream_arbiter #(.D_WIDTH(6), .N_REQ(4), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .up_data(ud1), .up_valid(v1), .up_ready(ur1),
    .down_data(dd1), .down_valid(dv1), .down_ready(dr1)
`ifdef RR_STREAM_ARBITER_SRC_ID_EN
    , .down_src(ds1)
`endif
  );

  rr_stream_arbiter #(.D_WIDTH(6), .N_REQ(4), .MAX_BURST(4)) dut4 (
    .clk(clk), .rst(rst), .up_data(ud4), .up_valid(v4), .up_ready(ur4),
    .down_data(dd4), .down_valid(dv4), .down_ready(dr4)
`ifdef RR_STREAM_ARBITER_SRC_ID_EN
    , .down_src(ds4)
`endif
  );

  always #5 clk = ~clk;

  // Each requester offers {index, sequence number}; the sequence advances on its transfers.
  for (genvar i = 0; i < 4; i++) begin : g_src
    assign ud1[i*6 +: 6] = {2'(i), seq1[i]};
    assign ud4[i*6 +: 6] = {2'(i), seq4[i]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        seq1[i] <= '0;
        seq4[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (v1[i] && ur1[i]) seq1[i] <= seq1[i] + 4'd1;
        if (v4[i] && ur4[i]) seq4[i] <= seq4[i] + 4'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic dv, input logic [5:0] dd,
                          input int src, input int sq);
    check({tag, "_valid"}, 32'(dv), 32'd1);
    check({tag, "_data"}, 32'(dd), 32'(src * 16 + sq));
  endtask

`ifdef RR_STREAM_ARBITER_SRC_ID_EN
  always @(negedge clk) begin
    if (rst && dv1) check("src_id1", 32'(ds1), 32'(dd1[5:4]));
    if (rst && dv4) check("src_id4", 32'(ds4), 32'(dd4[5:4]));
  end
`endif

  initial begin
    clk = 1'b0; rst = 1'b0;
    v1 = '0; v4 = '0; dr1 = 1'b1; dr4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dv1", 32'(dv1), 32'd0);
    check("rst_dd1", 32'(dd1), 32'd0);
    check("rst_ur1", 32'(ur1), 32'd0);
    check("rst_dv4", 32'(dv4), 32'd0);
    check("rst_dd4", 32'(dd4), 32'd0);
    check("rst_ur4", 32'(ur4), 32'd0);

    // All requesters valid: first grant is req0.
    rst = 1'b1; v1 = 4'hF; v4 = 4'hF;
    #1;
    check("first_ur1", 32'(ur1), 32'd1);
    check("first_ur4", 32'(ur4), 32'd1);
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      chk_beat($sformatf("fair%0d", k), dv1, dd1, k % 4, k / 4);
      chk_beat($sformatf("burst%0d", k), dv4, dd4, k / 4, k % 4);
    end

    // Reset mid-stream drops the registered beat immediately.
    #1; rst = 1'b0;
    #1;
    check("midrst_dv1", 32'(dv1), 32'd0);
    check("midrst_dd1", 32'(dd1), 32'd0);
    check("midrst_dv4", 32'(dv4), 32'd0);
    check("midrst_dd4", 32'(dd4), 32'd0);
    rst = 1'b1;

    // Backpressure on dut4 after its first beat.
    @(posedge clk); #1;
    chk_beat("bp_first4", dv4, dd4, 0, 0);
    chk_beat("bp_first1", dv1, dd1, 0, 0);
    check("bp_ur_pre", 32'(ur4), 32'd1);
    dr4 = 1'b0;
    #1;
    check("bp_ur_stall", 32'(ur4), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk_beat($sformatf("bp_hold%0d", k), dv4, dd4, 0, 0);
      check($sformatf("bp_ur%0d", k), 32'(ur4), 32'd0);
    end
    dr4 = 1'b1;
    for (int k = 1; k < 6; k++) begin
      @(posedge clk); #1;
      chk_beat($sformatf("bp_resume%0d", k), dv4, dd4, k / 4, k % 4);
    end

    // Early release: req2 runs out after two beats, req3 follows with no bubble.
    rst = 1'b0; #1; rst = 1'b1;
    v4 = 4'b1100; v1 = 4'b1010;
    @(posedge clk); #1;
    chk_beat("er_a4", dv4, dd4, 2, 0);
    chk_beat("er_a1", dv1, dd1, 1, 0);
    @(posedge clk); #1;
    chk_beat("er_b4", dv4, dd4, 2, 1);
    chk_beat("er_b1", dv1, dd1, 3, 0);
    v4 = 4'b1000;
    #1;
    check("er_rel_ur", 32'(ur4), 32'h8);
    @(posedge clk); #1;
    chk_beat("er_c4", dv4, dd4, 3, 0);
    chk_beat("er_c1", dv1, dd1, 1, 1);
    v4 = 4'b1100;
    #1;
    check("er_hold_ur", 32'(ur4), 32'h8);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      chk_beat($sformatf("er_r3_%0d", k), dv4, dd4, 3, k);
      chk_beat($sformatf("er_alt%0d", k), dv1, dd1, (k % 2 == 1) ? 3 : 1, (k + 1) / 2 + ((k % 2 == 1) ? 0 : 1));
    end
    @(posedge clk); #1;
    chk_beat("er_r2_turn", dv4, dd4, 2, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard bound on simulated time in case the sequence stalls.
  initial begin
    #20000;
    $display("FAIL timeout: sequence did not complete");
    $fatal(1, "timeout");
  end

endmodule
